// File: rtl/apu_shared_arbiter.sv
// apu_shared_arbiter: shares one APU between NB_CORES core-side dispatchers.
// Round-robin request arbitration, in-order tag FIFO of winning core IDs, and
// response routing back to the core at the FIFO head.
// Optional feature: define APU_ARB_PERF_EN to add contention_cnt_o, a 32-bit
// saturating count of cycles in which some requesting core was not granted.
module apu_shared_arbiter #(
    parameter int unsigned NB_CORES   = 4,
    parameter int unsigned OP_WIDTH   = 96,
    parameter int unsigned RES_WIDTH  = 32,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                             clk_i,
    input  logic                             rst_ni,
    input  logic [NB_CORES-1:0]              core_req_i,
    input  logic [NB_CORES*OP_WIDTH-1:0]     core_op_i,
    output logic [NB_CORES-1:0]              core_gnt_o,
    output logic [NB_CORES-1:0]              core_valid_o,
    output logic [RES_WIDTH-1:0]             core_result_o,
    output logic                             apu_req_o,
    output logic [OP_WIDTH-1:0]              apu_op_o,
    input  logic                             apu_gnt_i,
    input  logic                             apu_valid_i,
    input  logic [RES_WIDTH-1:0]             apu_result_i,
    output logic [$clog2(FIFO_DEPTH):0]      outstanding_o,
    output logic                             resp_err_o
`ifdef APU_ARB_PERF_EN
    ,
    output logic [31:0]                      contention_cnt_o
`endif
);

    localparam int unsigned IdxW = (NB_CORES > 1) ? $clog2(NB_CORES) : 1;
    localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CntW = PtrW + 1;
    localparam logic [CntW-1:0] FullCnt  = CntW'(FIFO_DEPTH);
    localparam logic [IdxW-1:0] LastCore = IdxW'(NB_CORES - 1);

    // Arbitration state
    logic [IdxW-1:0] r_rr;
    logic [IdxW-1:0] w_rr_next;
    logic [IdxW-1:0] w_winner;
    logic [IdxW-1:0] w_idx;
    logic            w_any_req;
    logic            w_found;

    // Tag FIFO state
    logic [IdxW-1:0] r_tag_mem [FIFO_DEPTH];
    logic [PtrW-1:0] r_head;
    logic [PtrW-1:0] r_tail;
    logic [CntW-1:0] r_count;
    logic            r_resp_err;

    logic            w_full;
    logic            w_empty;
    logic            w_can_issue;
    logic            w_push;
    logic            w_pop;
    logic [IdxW-1:0] w_head_id;

    // Round-robin search: first requester at or above r_rr, wrapping around.
    always_comb begin
        w_winner = '0;
        w_found  = 1'b0;
        w_idx    = '0;
        for (int unsigned i = 0; i < NB_CORES; i++) begin
            w_idx = IdxW'((32'(r_rr) + i) % NB_CORES);
            if (!w_found && core_req_i[w_idx]) begin
                w_found  = 1'b1;
                w_winner = w_idx;
            end
        end
    end

    assign w_any_req = |core_req_i;
    assign w_full    = (r_count == FullCnt);
    assign w_empty   = (r_count == '0);
    // A response popping this cycle frees a slot even when the FIFO is full.
    assign w_can_issue = !w_full || apu_valid_i;

    assign apu_req_o = w_any_req && w_can_issue;
    assign apu_op_o  = core_op_i[w_winner*OP_WIDTH +: OP_WIDTH];
    assign w_push    = apu_req_o && apu_gnt_i;
    assign w_pop     = apu_valid_i && !w_empty;
    assign w_head_id = r_tag_mem[r_head];

    assign w_rr_next = (w_winner == LastCore) ? '0 : w_winner + IdxW'(1);

    // Decode grant to the winner and response-valid to the FIFO head core.
    always_comb begin
        core_gnt_o   = '0;
        core_valid_o = '0;
        for (int unsigned i = 0; i < NB_CORES; i++) begin
            core_gnt_o[i]   = w_push && (w_winner == IdxW'(i));
            core_valid_o[i] = w_pop && (w_head_id == IdxW'(i));
        end
    end

    assign core_result_o = apu_result_i;
    assign outstanding_o = r_count;
    assign resp_err_o    = r_resp_err;

    // Priority pointer advances past the winner only on an accepted grant.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rr <= '0;
        end else if (w_push) begin
            r_rr <= w_rr_next;
        end
    end

    // Tag storage; contents are don't-care once pointers are reset.
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_tag_mem[r_tail] <= w_winner;
        end
    end

    // FIFO pointers and occupancy; simultaneous push and pop keep occupancy.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_tail <= r_tail + PtrW'(1);
            end
            if (w_pop) begin
                r_head <= r_head + PtrW'(1);
            end
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CntW'(1);
                2'b01:   r_count <= r_count - CntW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Sticky flag for a response that has no outstanding tag to match.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_resp_err <= 1'b0;
        end else if (apu_valid_i && w_empty) begin
            r_resp_err <= 1'b1;
        end
    end

`ifdef APU_ARB_PERF_EN
    logic [31:0] r_contention;
    logic        w_contend;

    assign w_contend        = |(core_req_i & ~core_gnt_o);
    assign contention_cnt_o = r_contention;

    // Saturating count of cycles with at least one requester left waiting.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_contention <= '0;
        end else if (w_contend && (r_contention != 32'hFFFF_FFFF)) begin
            r_contention <= r_contention + 32'd1;
        end
    end
`endif

`ifndef SYNTHESIS
    // Structural invariants on the decoded outputs.
    a_gnt_onehot : assert property (@(posedge clk_i) disable iff (!rst_ni)
        $onehot0(core_gnt_o));
    a_gnt_req : assert property (@(posedge clk_i) disable iff (!rst_ni)
        (core_gnt_o & ~core_req_i) == '0);
    a_valid_onehot : assert property (@(posedge clk_i) disable iff (!rst_ni)
        $onehot0(core_valid_o));
    a_no_overflow : assert property (@(posedge clk_i) disable iff (!rst_ni)
        r_count <= FullCnt);
`endif

endmodule

// File: doc/apu_shared_arbiter.md
# apu_shared_arbiter

Shares one APU (FP/DSP unit) between NB_CORES core-side APU dispatchers in a cluster. Grants one request per cycle using round-robin arbitration and records the winning core ID in an in-order tag FIFO. Routes each APU response back to the originating core by popping that FIFO. Sits between the per-core dispatcher master ports and the single APU slave port.

## Interface
Parameters:
- NB_CORES, 4: number of requesting cores, 2..8.
- OP_WIDTH, 96: opaque request payload width (operands, opcode, flags).
- RES_WIDTH, 32: result width.
- FIFO_DEPTH, 4: outstanding-request tag FIFO depth; power of two, ≥2.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- core_req_i  in  NB_CORES  per-core request.
- core_op_i  in  NB_CORES×OP_WIDTH  per-core payload.
- core_gnt_o  out  NB_CORES  per-core grant, one-hot or zero.
- core_valid_o  out  NB_CORES  per-core response valid, one-hot or zero.
- core_result_o  out  RES_WIDTH  result, broadcast to all cores.
- apu_req_o  out  1  request to the APU.
- apu_op_o  out  OP_WIDTH  payload of the selected core.
- apu_gnt_i  in  1  APU accepts the request.
- apu_valid_i  in  1  APU response valid. Responses are in order.
- apu_result_i  in  RES_WIDTH  APU result.
- outstanding_o  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy.
- resp_err_o  out  1  sticky: response received while the FIFO was empty.
- contention_cnt_o  out  32  stall-cycle counter. Present only with APU_ARB_PERF_EN.

## Operation
- Round-robin pointer rr_q (0..NB_CORES-1). The winner is the first core with core_req_i set, searching from rr_q upward with wrap-around.
- can_issue = !full | apu_valid_i. A pop in the same cycle frees a slot when the FIFO is full.
- apu_req_o = (|core_req_i) & can_issue. apu_op_o = core_op_i[winner]. The payload is held stable while the winner does not change.
- core_gnt_o[winner] = apu_req_o & apu_gnt_i. All other grant bits are 0.
- On an accepted grant:
  - push winner ID into the FIFO;
  - rr_q <= (winner+1) mod NB_CORES.
- Without an accepted grant, rr_q holds. A requester losing to a gnt-stalled APU keeps its priority order.
- When apu_valid_i is high and the FIFO is not empty:
  - core_valid_o[head] = 1;
  - core_result_o = apu_result_i;
  - pop the FIFO.
- When apu_valid_i is high and the FIFO is empty:
  - no core_valid_o bit is set;
  - resp_err_o <= 1 and stays set until reset.
- Push and pop in the same cycle leave occupancy unchanged. Head and tail pointers wrap modulo FIFO_DEPTH.
- Full (occupancy == FIFO_DEPTH) with no pop: apu_req_o = 0 and all grants are 0.

## Timing
- Request to grant is combinational, zero latency. Occupancy updates on the next edge.
- apu_valid_i to core_valid_o is combinational, zero latency.
- Reset values:
  - rr_q = 0, FIFO empty, outstanding_o = 0, resp_err_o = 0, contention_cnt_o = 0.
  - core_gnt_o, core_valid_o, apu_req_o are 0 while all inputs are 0.
- Reset asserted mid-operation flushes all outstanding tags. Responses arriving after reset set resp_err_o.
- The arbiter never grants a core whose core_req_i is 0.
- A core holds core_req_i and core_op_i until it sees core_gnt_o.

## Configuration
- APU_ARB_PERF_EN defined: contention_cnt_o is present.
  - It is a 32-bit saturating counter, incremented each cycle in which any core_req_i is high and that core's core_gnt_o is low.
  - At most +1 per cycle. It holds at 0xFFFF_FFFF.
- APU_ARB_PERF_EN undefined: the port and counter are omitted. All other behaviour is identical.

## Test plan
- Single core, NB_CORES=4: core 2 requests with apu_gnt_i=1 and the APU returns 3 cycles later -> core_gnt_o=4'b0100 same cycle; outstanding_o goes 1 then 0; core_valid_o=4'b0100 with the result.
- All four cores request continuously, apu_gnt_i=1, immediate responses -> grant order 0,1,2,3,0,… with exactly one grant per cycle.
- FIFO_DEPTH=4, APU withholds responses -> four grants, then apu_req_o=0. On the first apu_valid_i, a new grant and a pop in the same cycle; outstanding_o stays 4.
- apu_gnt_i=0 for 5 cycles while cores 1 and 3 request -> no grants, rr_q unchanged. When apu_gnt_i rises, core 1 wins first. With APU_ARB_PERF_EN, contention_cnt_o increases by 5 over the stall plus 1 for core 3 losing.
- apu_valid_i pulsed with an empty FIFO -> core_valid_o=0 and resp_err_o=1 until reset. Reset asserted with 3 tags outstanding -> outstanding_o=0 and rr_q=0 immediately.
